ripper_carry_adder: RTL and testbench

Parameterised ripple-carry adder with registered outputs, default 4 bits wide. It adds two unsigned operands and a carry-in through a chain of full-adder cells. The sum and carry-out are captured on the clock edge. It is a leaf arithmetic block in the datapath of the microprocessor, used wherever a small registered add with carry-in and carry-out is needed.

---
 rtl/adder_pkg.sv | 15 +
 rtl/full_adder.sv | 16 +
 rtl/ripper_carry_adder.sv | 62 ++++++
 tb/tb_ripper_carry_adder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared arithmetic definitions for the small datapath adders.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DEFAULT_ADD_WIDTH and the default-width sum/carry result struct used by the ALU.
package adder_pkg;

  localparam int DEFAULT_ADD_WIDTH = 4;

  // Result of a DEFAULT_ADD_WIDTH add; {cout, sum} is the full (WIDTH+1)-bit total.
  typedef struct packed {
    logic                         cout;
    logic [DEFAULT_ADD_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, the repeated stage of the ripple-carry chain.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, cin (inputs); s = a^b^cin, cout = majority(a, b, cin) (outputs).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripper_carry_adder.sv
// Registered unsigned ripple-carry adder: {cout, sum} <= A + B + cin0.
// Latency: 1 cycle; one result captured every rising clk edge.
// Backpressure: none (no enable, no handshake); rst clears outputs asynchronously.
// Ports: clk, rst (async active-high), A/B operands [WIDTH], cin0 carry-in,
//        sum [WIDTH] registered sum modulo 2^WIDTH, cout registered carry out of the MSB.
module ripper_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin0,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Carry chain c[0..WIDTH]: stage i receives c[i] in g_stage[i].c_in and
  // produces c[i+1] in g_stage[i].c_out. Each link is its own net so the
  // ripple stays an acyclic chain of distinct signals stage to stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic c_in;
    logic c_out;

    if (i == 0) begin : g_first
      assign c_in = cin0;
    end else begin : g_link
      assign c_in = g_stage[i-1].c_out;
    end

    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c_in),
      .s    (sum_d[i]),
      .cout (c_out)
    );
  end

  assign cout_d = g_stage[WIDTH-1].c_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_ripper_carry_adder.sv
// Self-checking bench for ripper_carry_adder at WIDTH = 4, 1 and 8.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: none; inputs are driven every cycle.
module tb_ripper_carry_adder;

  logic       clk;
  logic       rst;

  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] s4;
  logic       co4;

  logic [0:0] a1, b1;
  logic       c1;
  logic [0:0] s1;
  logic       co1;

  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8;
  logic       co8;

  int errs;
  int checks;

  ripper_carry_adder #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst (rst), .A (a4), .B (b4), .cin0 (c4), .sum (s4), .cout (co4)
  );

  ripper_carry_adder #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst), .A (a1), .B (b1), .cin0 (c1), .sum (s1), .cout (co1)
  );

  ripper_carry_adder #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .A (a8), .B (b8), .cin0 (c8), .sum (s8), .cout (co8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the (w+1)-bit arithmetic total of the operands.
  function automatic logic [31:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((a & mask) + (b & mask) + {31'd0, c}) & ((32'd1 << (w + 1)) - 32'd1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply a W4 vector, wait one edge, and compare against the reference.
  task automatic add4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c);
    a4 = a; b4 = b; c4 = c;
    @(posedge clk); #1;
    chk(tag, {27'd0, co4, s4}, ref_add(4, {28'd0, a}, {28'd0, b}, c));
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst = 1'b1;
    a4 = 4'h5; b4 = 4'hA; c4 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;

    // Reset state: asynchronous, so outputs must be zero before any edge.
    #1;
    chk("rst4_now", {27'd0, co4, s4}, 32'd0);
    chk("rst1_now", {30'd0, co1, s1}, 32'd0);
    chk("rst8_now", {23'd0, co8, s8}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst4_hold", {27'd0, co4, s4}, 32'd0);
    chk("rst8_hold", {23'd0, co8, s8}, 32'd0);
    rst = 1'b0;

    // Directed vectors; constants cross-check the model on the plan's values.
    add4("nominal", 4'b0110, 4'b1011, 1'b0);
    chk("nominal_const", {27'd0, co4, s4}, 32'h11);
    add4("cin_ripple", 4'b1111, 4'b0000, 1'b1);
    chk("cin_ripple_const", {27'd0, co4, s4}, 32'h10);
    add4("cin_part", 4'b0111, 4'b0000, 1'b1);
    chk("cin_part_const", {27'd0, co4, s4}, 32'h08);
    add4("zero", 4'h0, 4'h0, 1'b0);
    add4("max", 4'hF, 4'hF, 1'b1);
    chk("max_const", {27'd0, co4, s4}, 32'h1F);

    // Asynchronous reset between edges, then recapture after release.
    add4("pre_rst", 4'h9, 4'h9, 1'b0);
    chk("pre_rst_const", {27'd0, co4, s4}, 32'h12);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {27'd0, co4, s4}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", {27'd0, co4, s4}, 32'h12);

    // Latency: a mid-cycle input change must not reach the outputs before the edge.
    add4("lat_base", 4'h3, 4'h4, 1'b0);
    #3;
    a4 = 4'hC; b4 = 4'h7; c4 = 1'b1;
    #1;
    chk("lat_hold", {27'd0, co4, s4}, 32'h07);
    @(posedge clk); #1;
    chk("lat_new", {27'd0, co4, s4}, ref_add(4, 32'hC, 32'h7, 1'b1));

    // Exhaustive W4 sweep alongside random W1 and W8 vectors.
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0];
      b4 = i[7:4];
      c4 = i[8];
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      c1 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      c8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("sweep4", {27'd0, co4, s4}, ref_add(4, {28'd0, a4}, {28'd0, b4}, c4));
      chk("rand1", {30'd0, co1, s1}, ref_add(1, {31'd0, a1}, {31'd0, b1}, c1));
      chk("rand8", {23'd0, co8, s8}, ref_add(8, {24'd0, a8}, {24'd0, b8}, c8));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
